mul_div_unit: RTL and testbench
===============================

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 Parameter: ADDR_WIDTH, 32, datapath width of operands, HI and LO.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request a new operation; sampled only when busy=0.
REQ-005 op  input  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
REQ-006 rs_val  input  ADDR_WIDTH  first operand (multiplicand / dividend), from register file ReadData1.
REQ-007 rt_val  input  ADDR_WIDTH  second operand (multiplier / divisor), from register file ReadData2.
REQ-008 hi_we, lo_we  input  1 each  MTHI / MTLO write enables.
REQ-009 wdata  input  ADDR_WIDTH  data for MTHI / MTLO.
REQ-010 busy  output  1  operation in progress; the control unit stalls the PC while high.
REQ-011 done  output  1  one-cycle pulse when HI/LO take a new result.
REQ-012 hi, lo  output  ADDR_WIDTH each  architectural HI and LO registers, consumed by MFHI / MFLO writeback.
REQ-013 div_by_zero  output  1  set when the last DIV/DIVU had rt_val=0.

Function
REQ-014 States: IDLE, RUN, DONE.
REQ-015 IDLE/DONE with start=1: latch op and the operands, clear the iteration counter, enter RUN. Busy goes high after this edge (edge 0).
REQ-016 RUN executes one shift-add or shift-subtract step per cycle for exactly 32 cycles (edges 1..32).
REQ-017 Edge 32: write final HI/LO, enter DONE, assert done=1 and deassert busy in the same cycle.
REQ-018 DONE lasts one cycle and then returns to IDLE, unless a new start is accepted, which enters RUN directly. done=0 outside DONE.
REQ-019 Multiply: operate on magnitudes (signed ops take the absolute value of each operand), and negate the 64-bit product if the operand signs differ. Write {HI,LO}=64-bit product.
REQ-020 Divide: restoring division on magnitudes. LO=quotient truncated toward zero; HI=remainder carrying the sign of the dividend.
REQ-021 DIVU/DIV by zero: LO=32'hFFFFFFFF, HI=rs_val, div_by_zero=1. The unit still takes the full 33-cycle latency.
REQ-022 DIV with 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0, with no fault flag.
REQ-023 div_by_zero holds its value until the next accepted start, which clears it.
REQ-024 The unit ignores start while busy=1; latched operands and op stay unaffected.
REQ-025 hi_we/lo_we write wdata into HI/LO on the edge, only while busy=0. The unit ignores them while busy=1.
REQ-026 When start is accepted in the same cycle as hi_we/lo_we, start wins and the write is discarded.
REQ-027 hi and lo change only on REQ-017 or REQ-025. Intermediate values never appear on hi or lo.
REQ-028 All products and remainders are computed in 64-bit internal width. No truncation occurs before the final HI/LO split.

Reset
REQ-029 rst=1 forces, asynchronously: state=IDLE, busy=0, done=0, hi=0, lo=0, div_by_zero=0, iteration counter=0.
REQ-030 Reset during RUN aborts the operation. No partial result reaches HI/LO.
REQ-031 After rst deasserts, the first accepted start behaves exactly as REQ-015.

Verification
REQ-032 MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF -> after 33 edges: done=1, HI=0xFFFFFFFE, LO=0x00000001; busy high for 32 cycles.
REQ-033 MULT rs=-3 (0xFFFFFFFD), rt=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB.
REQ-034 DIV rs=-7, rt=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). DIVU rs=7, rt=0 -> LO=0xFFFFFFFF, HI=7, div_by_zero=1.
REQ-035 Start MULTU 5x6, then re-pulse start with DIVU at cycle 10 and hi_we at cycle 12 -> both ignored; HI=0, LO=30 at done.
REQ-036 Assert rst at cycle 20 of a DIV -> busy=0, HI=LO=0 immediately. A subsequent MTLO wdata=0x1234 -> LO=0x1234 next edge.
REQ-037 Back-to-back: start in the DONE cycle -> no IDLE cycle, busy=1 after that edge, second result correct.

Source files
------------

// File: rtl/mul_div_if.sv
// mul_div_if -- operation request / result bundle for mul_div_unit.
//   master: control unit side, drives start/op/operands and MTHI/MTLO writes,
//           observes busy/done, the HI/LO registers and the divide-by-zero flag.
//   slave : the multiply/divide unit itself.
interface mul_div_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  start;
  logic [1:0]            op;
  logic [ADDR_WIDTH-1:0] rs_val;
  logic [ADDR_WIDTH-1:0] rt_val;
  logic                  hi_we;
  logic                  lo_we;
  logic [ADDR_WIDTH-1:0] wdata;
  logic                  busy;
  logic                  done;
  logic [ADDR_WIDTH-1:0] hi;
  logic [ADDR_WIDTH-1:0] lo;
  logic                  div_by_zero;

  modport master (
    output start, op, rs_val, rt_val, hi_we, lo_we, wdata,
    input  busy, done, hi, lo, div_by_zero
  );

  modport slave (
    input  start, op, rs_val, rt_val, hi_we, lo_we, wdata,
    output busy, done, hi, lo, div_by_zero
  );
endinterface

// File: rtl/mul_div_unit.sv
// mul_div_unit -- iterative MIPS-style multiply/divide unit with HI/LO.
//   clk  : single clock, rising edge.
//   rst  : asynchronous active-high reset.
//   bus  : mul_div_if slave port
//          start/op/rs_val/rt_val   request (op: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU)
//          hi_we/lo_we/wdata        MTHI / MTLO writes (only while not busy)
//          busy/done                busy during the 32 iteration cycles, done pulses
//                                   for one cycle when HI/LO take the result
//          hi/lo                    architectural HI / LO registers
//          div_by_zero              last DIV/DIVU had a zero divisor
// One shift-add (multiply) or restoring shift-subtract (divide) step is done
// per cycle on operand magnitudes; signs are re-applied when the result is
// written to HI/LO on the last step.
module mul_div_unit #(
  parameter int ADDR_WIDTH = 32
) (
  input logic      clk,
  input logic      rst,
  mul_div_if.slave bus
);

  localparam int W  = ADDR_WIDTH;
  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST_STEP = CW'(W - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state_reg, state_next;

  logic [CW-1:0]  count_reg,    count_next;
  logic           is_div_reg,   is_div_next;
  logic           neg_q_reg,    neg_q_next;    // final product / quotient is negated
  logic           neg_r_reg,    neg_r_next;    // remainder takes the dividend's sign
  logic           zero_div_reg, zero_div_next; // divisor was zero
  logic [W-1:0]   rs_reg,       rs_next;       // original dividend, returned on divide by zero
  logic [2*W-1:0] acc_reg,      acc_next;      // product accumulator / partial remainder
  logic [2*W-1:0] mcand_reg,    mcand_next;    // shifting multiplicand / divisor magnitude
  logic [W-1:0]   quo_reg,      quo_next;      // multiplier shifter / dividend-to-quotient shifter
  logic [W-1:0]   hi_reg,       hi_next;
  logic [W-1:0]   lo_reg,       lo_next;
  logic           dbz_reg,      dbz_next;

  logic           accept;
  logic           last_step;
  logic           signed_op;
  logic           rs_neg, rt_neg;
  logic [W-1:0]   rs_mag, rt_mag;
  logic [2*W-1:0] acc_step, mcand_step, rem_shift, prod_signed;
  logic [W-1:0]   quo_step, quo_signed, rem_low, rem_signed;
  logic           busy_c, done_c;

  // Start is only honoured outside RUN, so an in-flight operation can never
  // be disturbed by a second request.
  assign accept    = bus.start && (state_reg != RUN);
  assign last_step = (state_reg == RUN) && (count_reg == LAST_STEP);

  // Operand magnitudes for the incoming request; op[0]=0 means signed.
  assign signed_op = ~bus.op[0];
  assign rs_neg    = signed_op & bus.rs_val[W-1];
  assign rt_neg    = signed_op & bus.rt_val[W-1];
  assign rs_mag    = rs_neg ? (~bus.rs_val + W'(1)) : bus.rs_val;
  assign rt_mag    = rt_neg ? (~bus.rt_val + W'(1)) : bus.rt_val;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    busy_c     = 1'b0;
    done_c     = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (accept) state_next = RUN;
      end
      RUN: begin
        busy_c = 1'b1;
        if (last_step) state_next = DONE;
      end
      DONE: begin
        done_c     = 1'b1;
        state_next = accept ? RUN : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // -------------------------------------------------------- one iteration
  always_comb begin
    rem_shift  = {acc_reg[2*W-2:0], quo_reg[W-1]};
    acc_step   = acc_reg;
    mcand_step = mcand_reg;
    quo_step   = quo_reg;
    if (is_div_reg) begin
      // Restoring division: bring down the next dividend bit, subtract the
      // divisor only when it fits, and shift the quotient bit in.
      if (rem_shift >= mcand_reg) begin
        acc_step = rem_shift - mcand_reg;
        quo_step = {quo_reg[W-2:0], 1'b1};
      end else begin
        acc_step = rem_shift;
        quo_step = {quo_reg[W-2:0], 1'b0};
      end
    end else begin
      // Shift-add multiply: add the shifted multiplicand for each set bit.
      if (quo_reg[0]) acc_step = acc_reg + mcand_reg;
      mcand_step = {mcand_reg[2*W-2:0], 1'b0};
      quo_step   = {1'b0, quo_reg[W-1:1]};
    end
  end

  // Sign correction of the values produced by the final iteration.
  assign prod_signed = neg_q_reg ? (~acc_step + (2*W)'(1)) : acc_step;
  assign quo_signed  = neg_q_reg ? (~quo_step + W'(1)) : quo_step;
  assign rem_low     = acc_step[W-1:0];
  assign rem_signed  = neg_r_reg ? (~rem_low + W'(1)) : rem_low;

  // ------------------------------------------------------ datapath next
  always_comb begin
    count_next    = count_reg;
    is_div_next   = is_div_reg;
    neg_q_next    = neg_q_reg;
    neg_r_next    = neg_r_reg;
    zero_div_next = zero_div_reg;
    rs_next       = rs_reg;
    acc_next      = acc_reg;
    mcand_next    = mcand_reg;
    quo_next      = quo_reg;
    hi_next       = hi_reg;
    lo_next       = lo_reg;
    dbz_next      = dbz_reg;

    if (accept) begin
      // Start beats a simultaneous MTHI/MTLO: the write is simply dropped.
      count_next    = '0;
      is_div_next   = bus.op[1];
      neg_q_next    = rs_neg ^ rt_neg;
      neg_r_next    = rs_neg;
      zero_div_next = (bus.rt_val == '0);
      rs_next       = bus.rs_val;
      acc_next      = '0;
      dbz_next      = 1'b0;
      if (bus.op[1]) begin
        mcand_next = {{W{1'b0}}, rt_mag};
        quo_next   = rs_mag;
      end else begin
        mcand_next = {{W{1'b0}}, rs_mag};
        quo_next   = rt_mag;
      end
    end else if (state_reg == RUN) begin
      count_next = count_reg + CW'(1);
      acc_next   = acc_step;
      mcand_next = mcand_step;
      quo_next   = quo_step;
      // HI/LO are touched only here, on the last step, so no partial value
      // is ever architecturally visible.
      if (last_step) begin
        if (!is_div_reg) begin
          hi_next  = prod_signed[2*W-1:W];
          lo_next  = prod_signed[W-1:0];
          dbz_next = 1'b0;
        end else if (zero_div_reg) begin
          hi_next  = rs_reg;
          lo_next  = '1;
          dbz_next = 1'b1;
        end else begin
          hi_next  = rem_signed;
          lo_next  = quo_signed;
          dbz_next = 1'b0;
        end
      end
    end else begin
      if (bus.hi_we) hi_next = bus.wdata;
      if (bus.lo_we) lo_next = bus.wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg    <= '0;
      is_div_reg   <= 1'b0;
      neg_q_reg    <= 1'b0;
      neg_r_reg    <= 1'b0;
      zero_div_reg <= 1'b0;
      rs_reg       <= '0;
      acc_reg      <= '0;
      mcand_reg    <= '0;
      quo_reg      <= '0;
      hi_reg       <= '0;
      lo_reg       <= '0;
      dbz_reg      <= 1'b0;
    end else begin
      count_reg    <= count_next;
      is_div_reg   <= is_div_next;
      neg_q_reg    <= neg_q_next;
      neg_r_reg    <= neg_r_next;
      zero_div_reg <= zero_div_next;
      rs_reg       <= rs_next;
      acc_reg      <= acc_next;
      mcand_reg    <= mcand_next;
      quo_reg      <= quo_next;
      hi_reg       <= hi_next;
      lo_reg       <= lo_next;
      dbz_reg      <= dbz_next;
    end
  end

  assign bus.busy        = busy_c;
  assign bus.done        = done_c;
  assign bus.hi          = hi_reg;
  assign bus.lo          = lo_reg;
  assign bus.div_by_zero = dbz_reg;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit -- directed vectors for mul_div_unit. Stimulus pushes the
// hand-computed HI/LO/div_by_zero expectation into a scoreboard queue; an
// independent monitor pops and compares whenever done is seen.
module tb_mul_div_unit;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  mul_div_if #(.ADDR_WIDTH(32)) bus ();

  mul_div_unit #(.ADDR_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  exp_t        sb[$];
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] model_hi = 32'h0;
  logic [31:0] model_lo = 32'h0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, req);
    end
  endtask

  // Monitor: compares HI/LO/div_by_zero against the scoreboard at each done.
  always @(negedge clk) begin
    if (!rst && bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=1 required=0");
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.name, "_hi"}, bus.hi, e.hi);
        check({e.name, "_lo"}, bus.lo, e.lo);
        check({e.name, "_dbz"}, {31'b0, bus.div_by_zero}, {31'b0, e.dbz});
        $display("txn %s: hi=0x%08h lo=0x%08h dbz=%0d", e.name, bus.hi, bus.lo, bus.div_by_zero);
      end
    end
  end

  // glitch: 0 none, 1 re-pulse start and hi_we mid-run, 2 MTHI in the start cycle.
  // back2back: issue start in the current (DONE) cycle without waiting.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el, input logic ed,
                        input string nm, input int glitch, input bit back2back);
    exp_t e;
    int   cnt;
    bit   seen;
    if (!back2back) @(negedge clk);
    bus.start  = 1'b1;
    bus.op     = o;
    bus.rs_val = a;
    bus.rt_val = b;
    if (glitch == 2) begin
      bus.hi_we = 1'b1;
      bus.wdata = 32'hBEEF_0000;
    end
    e.hi = eh; e.lo = el; e.dbz = ed; e.name = nm;
    sb.push_back(e);
    @(negedge clk);
    bus.start  = 1'b0;
    bus.hi_we  = 1'b0;
    bus.rs_val = 32'h1357_9BDF;
    bus.rt_val = 32'h2468_ACE0;
    check({nm, "_busy_after_start"}, {31'b0, bus.busy}, 32'd1);
    check({nm, "_dbz_cleared"}, {31'b0, bus.div_by_zero}, 32'd0);
    cnt  = 0;
    seen = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (bus.done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (bus.busy === 1'b1) cnt++;
      if (cnt == 32) begin
        check({nm, "_hold_hi"}, bus.hi, model_hi);
        check({nm, "_hold_lo"}, bus.lo, model_lo);
      end
      if (glitch == 1) begin
        if (cnt == 10) begin
          bus.start  = 1'b1;
          bus.op     = OP_DIVU;
          bus.rs_val = 32'd99;
          bus.rt_val = 32'd0;
        end
        if (cnt == 11) bus.start = 1'b0;
        if (cnt == 12) begin
          bus.hi_we = 1'b1;
          bus.wdata = 32'hDEAD_BEEF;
        end
        if (cnt == 13) bus.hi_we = 1'b0;
      end
      @(negedge clk);
    end
    check({nm, "_done_seen"}, {31'b0, seen}, 32'd1);
    check({nm, "_busy_cycles"}, cnt, 32'd32);
    check({nm, "_busy_at_done"}, {31'b0, bus.busy}, 32'd0);
    model_hi = eh;
    model_lo = el;
  endtask

  initial begin
    bus.start  = 1'b0;
    bus.op     = 2'b00;
    bus.rs_val = 32'h0;
    bus.rt_val = 32'h0;
    bus.hi_we  = 1'b0;
    bus.lo_we  = 1'b0;
    bus.wdata  = 32'h0;

    repeat (3) @(negedge clk);
    check("reset_busy", {31'b0, bus.busy}, 32'd0);
    check("reset_done", {31'b0, bus.done}, 32'd0);
    check("reset_hi", bus.hi, 32'h0);
    check("reset_lo", bus.lo, 32'h0);
    check("reset_dbz", {31'b0, bus.div_by_zero}, 32'd0);
    rst = 1'b0;

    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, "multu_max", 0, 1'b0);
    run_op(OP_MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, "mult_neg3x7", 0, 1'b0);
    run_op(OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, "mult_minxmin", 0, 1'b0);
    run_op(OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, "div_neg7by2", 0, 1'b0);
    run_op(OP_DIV,   32'd100,       32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFF2, 1'b0, "div_100byneg7", 0, 1'b0);
    run_op(OP_DIVU,  32'd7,         32'd0,         32'h0000_0007, 32'hFFFF_FFFF, 1'b1, "divu_by0", 0, 1'b0);
    run_op(OP_DIV,   32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1, "div_neg5by0", 0, 1'b0);
    run_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, "div_overflow", 0, 1'b0);
    run_op(OP_DIVU,  32'hFFFF_FFFF, 32'd16,        32'h0000_000F, 32'h0FFF_FFFF, 1'b0, "divu_max_by16", 0, 1'b0);
    run_op(OP_MULTU, 32'd5,         32'd6,         32'h0000_0000, 32'h0000_001E, 1'b0, "multu_ignore_restart", 1, 1'b0);
    run_op(OP_MULTU, 32'd2,         32'd3,         32'h0000_0000, 32'h0000_0006, 1'b0, "multu_start_beats_mthi", 2, 1'b0);

    // MTHI / MTLO while idle.
    @(negedge clk);
    bus.hi_we = 1'b1;
    bus.lo_we = 1'b1;
    bus.wdata = 32'hCAFE_F00D;
    @(negedge clk);
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    check("mt_both_hi", bus.hi, 32'hCAFE_F00D);
    check("mt_both_lo", bus.lo, 32'hCAFE_F00D);
    $display("txn mthi_mtlo: hi=0x%08h lo=0x%08h", bus.hi, bus.lo);
    model_hi = 32'hCAFE_F00D;
    model_lo = 32'hCAFE_F00D;

    // Back-to-back: second start issued in the DONE cycle of the first.
    run_op(OP_MULT, 32'hFFFF_FFFD, 32'd7,   32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, "b2b_first", 0, 1'b0);
    run_op(OP_DIVU, 32'd1000,      32'd7,   32'h0000_0006, 32'h0000_008E, 1'b0, "b2b_second", 0, 1'b1);

    // Reset in the middle of a DIV: no result may reach HI/LO.
    @(negedge clk);
    bus.start  = 1'b1;
    bus.op     = OP_DIV;
    bus.rs_val = 32'd100;
    bus.rt_val = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (19) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_mid_busy", {31'b0, bus.busy}, 32'd0);
    check("rst_mid_done", {31'b0, bus.done}, 32'd0);
    check("rst_mid_hi", bus.hi, 32'h0);
    check("rst_mid_lo", bus.lo, 32'h0);
    $display("txn reset_mid_div: busy=%0d hi=0x%08h lo=0x%08h", bus.busy, bus.hi, bus.lo);
    @(negedge clk);
    rst = 1'b0;
    model_hi = 32'h0;
    model_lo = 32'h0;
    @(negedge clk);
    bus.lo_we = 1'b1;
    bus.wdata = 32'h0000_1234;
    @(negedge clk);
    bus.lo_we = 1'b0;
    check("mtlo_after_rst_lo", bus.lo, 32'h0000_1234);
    check("mtlo_after_rst_hi", bus.hi, 32'h0);
    $display("txn mtlo_after_reset: hi=0x%08h lo=0x%08h", bus.hi, bus.lo);
    model_lo = 32'h0000_1234;

    // Quiet period: no stray done from the aborted operation.
    repeat (40) @(negedge clk);

    // First start after reset behaves normally.
    run_op(OP_DIV, 32'd100, 32'd7, 32'h0000_0002, 32'h0000_000E, 1'b0, "div_after_rst", 0, 1'b0);

    @(negedge clk);
    check("scoreboard_drained", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
